// File: rtl/ex_wb_ccr.sv
// ex_wb_ccr: execute/writeback boundary stage behind the 8-bit ALU.
//   Holds one writeback slot (result, destination, write enable) under a
//   valid/ready handshake, owns the condition code register {Z,N,C,V} with
//   per-opcode flag-update masks, and keeps a one-deep CCR shadow for
//   interrupt entry/return.
// Optional feature macro: OVF_TRAP_EN (overflow trap on ADD/SUB/INC/DEC).
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   in_valid / in_ready         ALU-side handshake (in_ready combinational)
//   opcode, ra, rd              instruction opcode, sub-op select, dest index
//   alu_out, alu_{c,z,n,v}      ALU result and flags
//   out_valid / out_ready       register-file-side handshake
//   out_result, out_rd,
//   out_wr_en                   registered writeback payload
//   flush                       squash the slot, block same-cycle accept
//   int_save, int_restore       CCR -> shadow, shadow -> CCR (both = swap)
//   ccr, ccr_c                  {Z,N,C,V} and carry-in back to the ALU
//   ovf_trap                    one-cycle overflow trap pulse (optional)
module ex_wb_ccr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [1:0]       ra,
  input  logic [1:0]       rd,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_c,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [1:0]       out_rd,
  output logic             out_wr_en,
  input  logic             flush,
  input  logic             int_save,
  input  logic             int_restore,
  output logic [3:0]       ccr,
  output logic             ccr_c,
  output logic             ovf_trap
);

  localparam int unsigned CCR_W = 4;

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_ROT = 4'b0110;
  localparam logic [3:0] OP_UNA = 4'b1000;

  // Flag masks in CCR bit order {Z,N,C,V}
  localparam logic [CCR_W-1:0] M_ALL = 4'b1111;
  localparam logic [CCR_W-1:0] M_ZN  = 4'b1100;
  localparam logic [CCR_W-1:0] M_C   = 4'b0010;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [1:0]       out_rd_q, out_rd_d;
  logic             out_wr_en_q, out_wr_en_d;
  logic [CCR_W-1:0] ccr_q, ccr_d;
  logic [CCR_W-1:0] shadow_q, shadow_d;

  logic             accept;
  logic             dec_wr;
  logic [CCR_W-1:0] dec_mask;
  logic             dec_setc;
  logic             dec_clrc;
  logic             dec_arith;
  logic             wr_eff;
  logic [CCR_W-1:0] flags_in;
  logic [CCR_W-1:0] ccr_upd;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign flags_in = {alu_z, alu_n, alu_c, alu_v};

  // Opcode decode: write enable, flag-update mask, explicit carry set/clear
  always_comb begin
    dec_wr    = 1'b0;
    dec_mask  = '0;
    dec_setc  = 1'b0;
    dec_clrc  = 1'b0;
    dec_arith = 1'b0;
    unique case (opcode)
      OP_MOV: dec_wr = 1'b1;
      OP_ADD, OP_SUB: begin
        dec_wr    = 1'b1;
        dec_mask  = M_ALL;
        dec_arith = 1'b1;
      end
      OP_AND, OP_OR: begin
        dec_wr   = 1'b1;
        dec_mask = M_ZN;
      end
      OP_ROT: begin
        unique case (ra)
          2'd0, 2'd1: begin
            dec_wr   = 1'b1;
            dec_mask = M_C;
          end
          2'd2:    dec_setc = 1'b1;
          default: dec_clrc = 1'b1;
        endcase
      end
      OP_UNA: begin
        dec_wr = 1'b1;
        if (ra[1]) begin
          dec_mask  = M_ALL;
          dec_arith = 1'b1;
        end else begin
          dec_mask = M_ZN;
        end
      end
      default: ;
    endcase
  end

`ifdef OVF_TRAP_EN
  logic trap_d, ovf_trap_q;

  // A signed overflow on an arithmetic op suppresses its writeback
  assign trap_d = accept && dec_arith && alu_v;
  assign wr_eff = dec_wr && !trap_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_trap_q <= 1'b0;
    else        ovf_trap_q <= trap_d;
  end

  assign ovf_trap = ovf_trap_q;
`else
  logic unused_arith;

  assign unused_arith = dec_arith;
  assign wr_eff       = dec_wr;
  assign ovf_trap     = 1'b0;
`endif

  // Masked flag merge; unmasked flags hold
  always_comb begin
    ccr_upd = (ccr_q & ~dec_mask) | (flags_in & dec_mask);
    if (dec_setc) ccr_upd[1] = 1'b1;
    if (dec_clrc) ccr_upd[1] = 1'b0;
  end

  // CCR/shadow next state: restore wins over any update, save sees pre-update CCR
  always_comb begin
    ccr_d    = ccr_q;
    shadow_d = shadow_q;
    if (accept)      ccr_d    = ccr_upd;
    if (int_restore) ccr_d    = shadow_q;
    if (int_save)    shadow_d = ccr_q;
  end

  // Writeback slot next state
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    out_wr_en_d  = out_wr_en_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_out;
      out_rd_d     = rd;
      out_wr_en_d  = wr_eff;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= WIDTH'(0);
      out_rd_q     <= 2'd0;
      out_wr_en_q  <= 1'b0;
      ccr_q        <= CCR_W'(0);
      shadow_q     <= CCR_W'(0);
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      out_wr_en_q  <= out_wr_en_d;
      ccr_q        <= ccr_d;
      shadow_q     <= shadow_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_rd     = out_rd_q;
  assign out_wr_en  = out_wr_en_q;
  assign ccr        = ccr_q;
  assign ccr_c      = ccr_q[1];

endmodule

// File: tb/tb_ex_wb_ccr.sv
// tb_ex_wb_ccr: self-checking bench for ex_wb_ccr with directed scenarios
// and randomized traffic compared against a behavioural model.
module tb_ex_wb_ccr;

  localparam int unsigned WIDTH = 8;
`ifdef OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid, in_ready;
  logic [3:0]       opcode;
  logic [1:0]       ra, rd;
  logic [WIDTH-1:0] alu_out;
  logic             alu_c, alu_z, alu_n, alu_v;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_result;
  logic [1:0]       out_rd;
  logic             out_wr_en;
  logic             flush, int_save, int_restore;
  logic [3:0]       ccr;
  logic             ccr_c;
  logic             ovf_trap;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit             m_valid;
  bit [WIDTH-1:0] m_result;
  bit [1:0]       m_rd;
  bit             m_wr;
  bit [3:0]       m_ccr;
  bit [3:0]       m_shadow;
  bit             m_trap;

  ex_wb_ccr #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .ra(ra), .rd(rd), .alu_out(alu_out),
    .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wr_en(out_wr_en),
    .flush(flush), .int_save(int_save), .int_restore(int_restore),
    .ccr(ccr), .ccr_c(ccr_c), .ovf_trap(ovf_trap)
  );

  always #5 clk = ~clk;

  // Instruction semantics: which flags each mnemonic writes
  function automatic void decode_ref(input bit [3:0] op, input bit [1:0] sub,
                                     output bit wr, output bit fz, output bit fn,
                                     output bit fc, output bit fv, output bit setc,
                                     output bit clrc, output bit arith);
    wr = 0; fz = 0; fn = 0; fc = 0; fv = 0; setc = 0; clrc = 0; arith = 0;
    case (op)
      4'd1: wr = 1;                                              // MOV
      4'd2, 4'd3: begin wr = 1; fz = 1; fn = 1; fc = 1; fv = 1; arith = 1; end // ADD SUB
      4'd4, 4'd5: begin wr = 1; fz = 1; fn = 1; end              // AND OR
      4'd6: begin
        if (sub == 0 || sub == 1) begin wr = 1; fc = 1; end      // RLC RRC
        else if (sub == 2) setc = 1;                             // SETC
        else clrc = 1;                                           // CLRC
      end
      4'd8: begin
        wr = 1; fz = 1; fn = 1;                                  // NOT NEG
        if (sub >= 2) begin fc = 1; fv = 1; arith = 1; end       // INC DEC
      end
      default: ;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_result = '0; m_rd = 0; m_wr = 0;
    m_ccr = 0; m_shadow = 0; m_trap = 0;
  endtask

  // Advance the model by one edge using the inputs currently driven
  task automatic model_step();
    bit acc, wr, fz, fn, fc, fv, sc, cc, ar, trap;
    bit z, n, c, v;
    bit [3:0] old_ccr;
    acc = in_valid && (!m_valid || out_ready) && !flush;
    decode_ref(opcode, ra, wr, fz, fn, fc, fv, sc, cc, ar);
    z = m_ccr[3]; n = m_ccr[2]; c = m_ccr[1]; v = m_ccr[0];
    if (acc) begin
      if (fz) z = alu_z;
      if (fn) n = alu_n;
      if (fc) c = alu_c;
      if (fv) v = alu_v;
      if (sc) c = 1;
      if (cc) c = 0;
    end
    trap = TRAP_EN && acc && ar && alu_v;
    old_ccr = m_ccr;
    m_ccr = int_restore ? m_shadow : {z, n, c, v};
    if (int_save) m_shadow = old_ccr;
    if (flush) m_valid = 0;
    else if (acc) begin
      m_valid = 1; m_result = alu_out; m_rd = rd; m_wr = wr && !trap;
    end else if (m_valid && out_ready) m_valid = 0;
    m_trap = trap;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; opcode = 0; ra = 0; rd = 0; alu_out = '0;
    alu_c = 0; alu_z = 0; alu_n = 0; alu_v = 0;
    out_ready = 1; flush = 0; int_save = 0; int_restore = 0;
  endtask

  task automatic set_op(input bit [3:0] op, input bit [1:0] sub, input bit [WIDTH-1:0] res,
                        input bit z, input bit n, input bit c, input bit v);
    in_valid = 1; opcode = op; ra = sub; rd = 2'($urandom);
    alu_out = res; alu_z = z; alu_n = n; alu_c = c; alu_v = v;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_result !== '0 || out_rd !== 2'd0 || out_wr_en !== 1'b0) begin
      bad++; $display("FAIL reset_payload got=%h/%h/%b exp=00/0/0", out_result, out_rd, out_wr_en); end
    total++; if (ccr !== 4'b0000 || ovf_trap !== 1'b0) begin
      bad++; $display("FAIL reset_ccr got=%b trap=%b exp=0000 trap=0", ccr, ovf_trap); end
    rst_n = 1;
    model_reset();
    // Load the slot and CCR, then reset between edges
    set_op(4'd2, 0, 8'h11, 1, 0, 0, 0);
    out_ready = 0;
    tick();
    total++; if (out_valid !== 1'b1 || ccr !== 4'b1000) begin
      bad++; $display("FAIL pre_reset got valid=%b ccr=%b exp valid=1 ccr=1000", out_valid, ccr); end
    idle();
    out_ready = 0;
    #2 rst_n = 0;
    #1;
    total++; if (out_valid !== 1'b0 || ccr !== 4'b0000) begin
      bad++; $display("FAIL async_reset got valid=%b ccr=%b exp valid=0 ccr=0000", out_valid, ccr); end
    model_reset();
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_flags();
    idle();
    set_op(4'd2, 0, 8'h00, 1, 0, 1, 0);
    tick();
    total++; if (ccr !== 4'b1010 || out_result !== 8'h00 || out_wr_en !== 1'b1) begin
      bad++; $display("FAIL flags_add got ccr=%b res=%h wr=%b exp ccr=1010 res=00 wr=1", ccr, out_result, out_wr_en); end
    set_op(4'd4, 0, 8'h80, 0, 1, 0, 1);
    tick();
    total++; if (ccr !== 4'b0110 || out_result !== 8'h80) begin
      bad++; $display("FAIL flags_and got ccr=%b res=%h exp ccr=0110 res=80", ccr, out_result); end
    set_op(4'd6, 2, 8'($urandom), 1, 1, 0, 1);
    tick();
    total++; if (ccr !== 4'b0110 || ccr_c !== 1'b1 || out_wr_en !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL flags_setc got ccr=%b c=%b wr=%b exp ccr=0110 c=1 wr=0", ccr, ccr_c, out_wr_en); end
    set_op(4'd6, 3, 8'($urandom), 1, 1, 1, 1);
    tick();
    total++; if (ccr !== 4'b0100 || ccr_c !== 1'b0 || out_wr_en !== 1'b0) begin
      bad++; $display("FAIL flags_clrc got ccr=%b c=%b wr=%b exp ccr=0100 c=0 wr=0", ccr, ccr_c, out_wr_en); end
    set_op(4'd6, 1, 8'h81, 0, 0, 1, 1);
    tick();
    total++; if (ccr !== 4'b0110 || out_wr_en !== 1'b1 || out_result !== 8'h81) begin
      bad++; $display("FAIL flags_rrc got ccr=%b wr=%b res=%h exp ccr=0110 wr=1 res=81", ccr, out_wr_en, out_result); end
    set_op(4'd0, 0, 8'h5A, 1, 0, 0, 1);
    tick();
    total++; if (ccr !== 4'b0110 || out_wr_en !== 1'b0) begin
      bad++; $display("FAIL flags_nop got ccr=%b wr=%b exp ccr=0110 wr=0", ccr, out_wr_en); end
    idle();
    tick();
  endtask

  task automatic test_backpressure();
    idle();
    set_op(4'd2, 0, 8'hA1, 0, 1, 0, 0);
    tick();
    total++; if (out_valid !== 1'b1 || out_result !== 8'hA1) begin
      bad++; $display("FAIL bp_first got valid=%b res=%h exp valid=1 res=a1", out_valid, out_result); end
    out_ready = 0;
    set_op(4'd2, 0, 8'hA2, 0, 1, 1, 0);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_result !== 8'hA1) begin
        bad++; $display("FAIL bp_hold got valid=%b res=%h exp valid=1 res=a1", out_valid, out_result); end
    end
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1 || out_result !== 8'hA2) begin
      bad++; $display("FAIL bp_second got valid=%b res=%h exp valid=1 res=a2", out_valid, out_result); end
    set_op(4'd2, 0, 8'hA3, 1, 0, 1, 0);
    tick();
    total++; if (out_valid !== 1'b1 || out_result !== 8'hA3 || ccr !== m_ccr) begin
      bad++; $display("FAIL bp_third got valid=%b res=%h ccr=%b exp valid=1 res=a3 ccr=%b", out_valid, out_result, ccr, m_ccr); end
    idle();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_interrupts();
    idle();
    set_op(4'd2, 0, 8'h00, 1, 0, 0, 1);
    tick();
    total++; if (ccr !== 4'b1001) begin bad++; $display("FAIL int_setup got=%b exp=1001", ccr); end
    idle(); int_save = 1;
    tick();
    idle();
    set_op(4'd3, 0, 8'hF0, 0, 1, 0, 0);
    tick();
    total++; if (ccr !== 4'b0100) begin bad++; $display("FAIL int_sub got=%b exp=0100", ccr); end
    idle(); int_restore = 1;
    tick();
    total++; if (ccr !== 4'b1001) begin bad++; $display("FAIL int_restore got=%b exp=1001", ccr); end
    idle();
    set_op(4'd2, 0, 8'h02, 0, 0, 1, 0);
    tick();
    total++; if (ccr !== 4'b0010) begin bad++; $display("FAIL int_pre_swap got=%b exp=0010", ccr); end
    idle(); int_save = 1; int_restore = 1;
    tick();
    total++; if (ccr !== 4'b1001) begin bad++; $display("FAIL int_swap_ccr got=%b exp=1001", ccr); end
    idle(); int_restore = 1;
    tick();
    total++; if (ccr !== 4'b0010) begin bad++; $display("FAIL int_swap_shadow got=%b exp=0010", ccr); end
    // Restore overrides the accepted instruction's flags; the slot still loads
    idle();
    set_op(4'd2, 0, 8'h55, 1, 1, 0, 1);
    int_restore = 1;
    tick();
    total++; if (ccr !== 4'b0010 || out_valid !== 1'b1 || out_result !== 8'h55) begin
      bad++; $display("FAIL int_override got ccr=%b valid=%b res=%h exp ccr=0010 valid=1 res=55", ccr, out_valid, out_result); end
    idle();
    tick();
  endtask

  task automatic test_flush();
    idle();
    set_op(4'd2, 0, 8'h3C, 0, 0, 1, 0);
    tick();
    total++; if (out_valid !== 1'b1 || ccr !== 4'b0010) begin
      bad++; $display("FAIL flush_setup got valid=%b ccr=%b exp valid=1 ccr=0010", out_valid, ccr); end
    set_op(4'd2, 0, 8'hC3, 1, 1, 0, 1);
    flush = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0 || ccr !== 4'b0010) begin
      bad++; $display("FAIL flush_squash got valid=%b ccr=%b exp valid=0 ccr=0010", out_valid, ccr); end
    idle();
    set_op(4'd4, 0, 8'h00, 1, 0, 0, 0);
    tick();
    idle(); out_ready = 0; flush = 1;
    tick();
    total++; if (out_valid !== 1'b0 || ccr !== 4'b1010) begin
      bad++; $display("FAIL flush_stalled got valid=%b ccr=%b exp valid=0 ccr=1010", out_valid, ccr); end
    idle();
  endtask

  task automatic test_ovf();
    idle();
    set_op(4'd2, 0, 8'h80, 0, 1, 0, 1);
    tick();
    total++; if (ovf_trap !== TRAP_EN || out_wr_en !== !TRAP_EN || ccr[0] !== 1'b1 || out_result !== 8'h80) begin
      bad++; $display("FAIL ovf_add got trap=%b wr=%b v=%b res=%h exp trap=%b wr=%b v=1 res=80",
                      ovf_trap, out_wr_en, ccr[0], out_result, TRAP_EN, !TRAP_EN); end
    idle();
    tick();
    total++; if (ovf_trap !== 1'b0) begin bad++; $display("FAIL ovf_pulse got=%b exp=0", ovf_trap); end
    set_op(4'd3, 0, 8'h7F, 0, 0, 1, 1);
    flush = 1;
    tick();
    total++; if (ovf_trap !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL ovf_flush got trap=%b valid=%b exp trap=0 valid=0", ovf_trap, out_valid); end
    idle();
    set_op(4'd8, 3, 8'h7F, 0, 0, 0, 1);
    tick();
    total++; if (ovf_trap !== TRAP_EN || out_wr_en !== !TRAP_EN) begin
      bad++; $display("FAIL ovf_dec got trap=%b wr=%b exp trap=%b wr=%b", ovf_trap, out_wr_en, TRAP_EN, !TRAP_EN); end
    idle();
    set_op(4'd4, 0, 8'h7F, 0, 0, 0, 1);
    tick();
    total++; if (ovf_trap !== 1'b0 || out_wr_en !== 1'b1) begin
      bad++; $display("FAIL ovf_logic got trap=%b wr=%b exp trap=0 wr=1", ovf_trap, out_wr_en); end
    idle();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      in_valid    = ($urandom % 4) != 0;
      opcode      = 4'($urandom);
      ra          = 2'($urandom);
      rd          = 2'($urandom);
      alu_out     = WIDTH'($urandom);
      alu_z       = 1'($urandom); alu_n = 1'($urandom);
      alu_c       = 1'($urandom); alu_v = 1'($urandom);
      out_ready   = ($urandom % 4) != 0;
      flush       = ($urandom % 10) == 0;
      int_save    = ($urandom % 12) == 0;
      int_restore = ($urandom % 12) == 0;
      #1;
      total++; if (in_ready !== (!m_valid || out_ready)) begin
        bad++; $display("FAIL rnd_in_ready i=%0d got=%b exp=%b", i, in_ready, !m_valid || out_ready); end
      tick();
      total++; if (out_valid !== m_valid) begin
        bad++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, out_valid, m_valid); end
      if (m_valid) begin
        total++; if (out_result !== m_result || out_rd !== m_rd || out_wr_en !== m_wr) begin
          bad++; $display("FAIL rnd_payload i=%0d got=%h/%h/%b exp=%h/%h/%b",
                          i, out_result, out_rd, out_wr_en, m_result, m_rd, m_wr); end
      end
      total++; if (ccr !== m_ccr || ccr_c !== m_ccr[1]) begin
        bad++; $display("FAIL rnd_ccr i=%0d got=%b c=%b exp=%b", i, ccr, ccr_c, m_ccr); end
      total++; if (ovf_trap !== m_trap) begin
        bad++; $display("FAIL rnd_trap i=%0d got=%b exp=%b", i, ovf_trap, m_trap); end
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_flags();
    test_backpressure();
    test_interrupts();
    test_flush();
    test_ovf();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
